// File: rtl/pipe_pkg.sv
// Shared widths, the zero-register constant and the ID/EX control bundle.
package pipe_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    // Control fields carried alongside the operands in the ID/EX register.
    typedef struct packed {
        logic              valid;
        logic              regwrite;
        logic              memread;
        logic [REG_AW-1:0] dest;
    } idex_ctrl_t;

endpackage

// File: rtl/operand_bypass_mux.sv
// Resolves one source operand: zero register, MEM bypass, WB bypass or
// register-file data, and flags when the value cannot be produced yet.
module operand_bypass_mux #(
    parameter int DATA_W = pipe_pkg::DATA_W,
    parameter int REG_AW = pipe_pkg::REG_AW
) (
    input  logic [REG_AW-1:0] src,
    input  logic              uses_src,
    input  logic [DATA_W-1:0] reg_data,
    input  logic              ex_valid,
    input  logic              ex_regwrite,
    input  logic [REG_AW-1:0] ex_dest,
    input  logic              mem_regwrite,
    input  logic              mem_memread,
    input  logic [REG_AW-1:0] mem_dest,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_dest,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] data,
    output logic              hazard
);
    import pipe_pkg::REG_ZERO;

    logic src_nonzero;
    logic ex_pending;
    logic mem_load_pending;

    assign src_nonzero      = (src != REG_AW'(REG_ZERO));
    // Producer still in EX: its result does not exist this cycle.
    assign ex_pending       = ex_valid && ex_regwrite && (ex_dest == src);
    // Load in MEM: its data only appears once it reaches WB.
    assign mem_load_pending = mem_regwrite && mem_memread && (mem_dest == src);

    // Data selection; MEM is checked before WB because it holds the younger value.
    always_comb begin
        data = reg_data;
        if (!src_nonzero) begin
            data = '0;
        end else if (mem_regwrite && !mem_memread && (mem_dest == src)) begin
            data = mem_result;
        end else if (wb_we && (wb_dest == src)) begin
            data = wb_data;
        end
    end

    assign hazard = uses_src && src_nonzero && (ex_pending || mem_load_pending);

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX stage: bypasses both operands, raises the interlock stall and
// latches the resolved instruction into the register feeding the ALU.
module id_ex_operand_stage #(
    parameter int DATA_W = pipe_pkg::DATA_W,
    parameter int REG_AW = pipe_pkg::REG_AW,
    parameter int CNT_W  = 32
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              InstrValid_IN,
    input  logic [REG_AW-1:0] Rs_IN,
    input  logic [REG_AW-1:0] Rt_IN,
    input  logic [REG_AW-1:0] Dest_IN,
    input  logic              UsesRs_IN,
    input  logic              UsesRt_IN,
    input  logic              RegWrite_IN,
    input  logic              MemRead_IN,
    input  logic [DATA_W-1:0] RegData1_IN,
    input  logic [DATA_W-1:0] RegData2_IN,
    input  logic              MEMRegWrite_IN,
    input  logic              MEMMemRead_IN,
    input  logic [REG_AW-1:0] MEMDest_IN,
    input  logic [DATA_W-1:0] MEMResult_IN,
    input  logic              WBWriteEnable_IN,
    input  logic [REG_AW-1:0] WBWriteRegister_IN,
    input  logic [DATA_W-1:0] WBWriteData_IN,
    input  logic              Flush_IN,
    output logic              Stall_OUT,
    output logic              EXValid_OUT,
    output logic [DATA_W-1:0] EXOperandA_OUT,
    output logic [DATA_W-1:0] EXOperandB_OUT,
    output logic [REG_AW-1:0] EXDest_OUT,
    output logic              EXRegWrite_OUT,
    output logic              EXMemRead_OUT,
    output logic [CNT_W-1:0]  StallCount_OUT
);
    import pipe_pkg::idex_ctrl_t;

    localparam int CTRL_AW = $bits(idex_ctrl_t) - 3;

    idex_ctrl_t        ctrl_q, ctrl_d;
    logic [DATA_W-1:0] opa_q, opa_d;
    logic [DATA_W-1:0] opb_q, opb_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [DATA_W-1:0] opa_res, opb_res;
    logic              haz_a, haz_b;
    logic [REG_AW-1:0] ex_dest;
    logic              stall;

    assign ex_dest = REG_AW'(ctrl_q.dest);

    operand_bypass_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_mux_rs (
        .src(Rs_IN), .uses_src(UsesRs_IN), .reg_data(RegData1_IN),
        .ex_valid(ctrl_q.valid), .ex_regwrite(ctrl_q.regwrite), .ex_dest(ex_dest),
        .mem_regwrite(MEMRegWrite_IN), .mem_memread(MEMMemRead_IN),
        .mem_dest(MEMDest_IN), .mem_result(MEMResult_IN),
        .wb_we(WBWriteEnable_IN), .wb_dest(WBWriteRegister_IN), .wb_data(WBWriteData_IN),
        .data(opa_res), .hazard(haz_a)
    );

    operand_bypass_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_mux_rt (
        .src(Rt_IN), .uses_src(UsesRt_IN), .reg_data(RegData2_IN),
        .ex_valid(ctrl_q.valid), .ex_regwrite(ctrl_q.regwrite), .ex_dest(ex_dest),
        .mem_regwrite(MEMRegWrite_IN), .mem_memread(MEMMemRead_IN),
        .mem_dest(MEMDest_IN), .mem_result(MEMResult_IN),
        .wb_we(WBWriteEnable_IN), .wb_dest(WBWriteRegister_IN), .wb_data(WBWriteData_IN),
        .data(opb_res), .hazard(haz_b)
    );

    // Gated by reset so a load sitting in MEM cannot stall a held pipeline.
    assign stall     = RESET && InstrValid_IN && !Flush_IN && (haz_a || haz_b);
    assign Stall_OUT = stall;

    // Next ID/EX contents: flush and stall both produce an all-zero bubble.
    always_comb begin
        ctrl_d = '0;
        opa_d  = '0;
        opb_d  = '0;
        if (!Flush_IN && !stall) begin
            ctrl_d.valid    = InstrValid_IN;
            ctrl_d.regwrite = InstrValid_IN && RegWrite_IN;
            ctrl_d.memread  = InstrValid_IN && MemRead_IN;
            ctrl_d.dest     = CTRL_AW'(Dest_IN);
            opa_d           = opa_res;
            opb_d           = opb_res;
        end
    end

    // Stall-cycle counter that sticks at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Pipeline register and counter state.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            ctrl_q <= '0;
            opa_q  <= '0;
            opb_q  <= '0;
            cnt_q  <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            opa_q  <= opa_d;
            opb_q  <= opb_d;
            cnt_q  <= cnt_d;
        end
    end

    assign EXValid_OUT    = ctrl_q.valid;
    assign EXRegWrite_OUT = ctrl_q.regwrite;
    assign EXMemRead_OUT  = ctrl_q.memread;
    assign EXDest_OUT     = ex_dest;
    assign EXOperandA_OUT = opa_q;
    assign EXOperandB_OUT = opb_q;
    assign StallCount_OUT = cnt_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for the ID/EX operand stage; expected EX contents are
// queued when an instruction is driven and compared after the edge.
module tb_id_ex_operand_stage;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 2;   // narrow counter so saturation is reachable

    logic          CLOCK, RESET;
    logic          InstrValid_IN, UsesRs_IN, UsesRt_IN, RegWrite_IN, MemRead_IN;
    logic [AW-1:0] Rs_IN, Rt_IN, Dest_IN;
    logic [DW-1:0] RegData1_IN, RegData2_IN;
    logic          MEMRegWrite_IN, MEMMemRead_IN;
    logic [AW-1:0] MEMDest_IN;
    logic [DW-1:0] MEMResult_IN;
    logic          WBWriteEnable_IN;
    logic [AW-1:0] WBWriteRegister_IN;
    logic [DW-1:0] WBWriteData_IN;
    logic          Flush_IN;
    logic          Stall_OUT, EXValid_OUT, EXRegWrite_OUT, EXMemRead_OUT;
    logic [DW-1:0] EXOperandA_OUT, EXOperandB_OUT;
    logic [AW-1:0] EXDest_OUT;
    logic [CW-1:0] StallCount_OUT;

    id_ex_operand_stage #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .InstrValid_IN(InstrValid_IN), .Rs_IN(Rs_IN), .Rt_IN(Rt_IN), .Dest_IN(Dest_IN),
        .UsesRs_IN(UsesRs_IN), .UsesRt_IN(UsesRt_IN),
        .RegWrite_IN(RegWrite_IN), .MemRead_IN(MemRead_IN),
        .RegData1_IN(RegData1_IN), .RegData2_IN(RegData2_IN),
        .MEMRegWrite_IN(MEMRegWrite_IN), .MEMMemRead_IN(MEMMemRead_IN),
        .MEMDest_IN(MEMDest_IN), .MEMResult_IN(MEMResult_IN),
        .WBWriteEnable_IN(WBWriteEnable_IN), .WBWriteRegister_IN(WBWriteRegister_IN),
        .WBWriteData_IN(WBWriteData_IN), .Flush_IN(Flush_IN),
        .Stall_OUT(Stall_OUT), .EXValid_OUT(EXValid_OUT),
        .EXOperandA_OUT(EXOperandA_OUT), .EXOperandB_OUT(EXOperandB_OUT),
        .EXDest_OUT(EXDest_OUT), .EXRegWrite_OUT(EXRegWrite_OUT),
        .EXMemRead_OUT(EXMemRead_OUT), .StallCount_OUT(StallCount_OUT)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    typedef struct {
        bit          full;   // 0: bubble, only valid/control/count are defined
        logic        valid;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  dest;
        logic        rw;
        logic        mr;
        logic [1:0]  cnt;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic idle();
        InstrValid_IN = 0; Rs_IN = 0; Rt_IN = 0; Dest_IN = 0;
        UsesRs_IN = 0; UsesRt_IN = 0; RegWrite_IN = 0; MemRead_IN = 0;
        RegData1_IN = 0; RegData2_IN = 0;
        MEMRegWrite_IN = 0; MEMMemRead_IN = 0; MEMDest_IN = 0; MEMResult_IN = 0;
        WBWriteEnable_IN = 0; WBWriteRegister_IN = 0; WBWriteData_IN = 0;
        Flush_IN = 0;
    endtask

    task automatic id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dest,
                      input logic urs, input logic urt, input logic rw, input logic mr,
                      input logic [31:0] d1, input logic [31:0] d2);
        InstrValid_IN = 1; Rs_IN = rs; Rt_IN = rt; Dest_IN = dest;
        UsesRs_IN = urs; UsesRt_IN = urt; RegWrite_IN = rw; MemRead_IN = mr;
        RegData1_IN = d1; RegData2_IN = d2;
    endtask

    task automatic mem(input logic rw, input logic mr, input logic [4:0] dest, input logic [31:0] res);
        MEMRegWrite_IN = rw; MEMMemRead_IN = mr; MEMDest_IN = dest; MEMResult_IN = res;
    endtask

    task automatic wb(input logic we, input logic [4:0] r, input logic [31:0] d);
        WBWriteEnable_IN = we; WBWriteRegister_IN = r; WBWriteData_IN = d;
    endtask

    task automatic check_stall(input string tag, input logic exp_v);
        #1;
        chk(tag, {31'b0, Stall_OUT}, {31'b0, exp_v});
    endtask

    // Queue the expected EX contents, clock once, then compare the oldest entry.
    task automatic step(input string tag, input bit full, input logic valid,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] dest,
                        input logic rw, input logic mr, input logic [1:0] cnt);
        exp_t e;
        e.full = full; e.valid = valid; e.a = a; e.b = b;
        e.dest = dest; e.rw = rw; e.mr = mr; e.cnt = cnt;
        sb.push_back(e);
        @(posedge CLOCK);
        #1;
        e = sb.pop_front();
        $display("txn %s: valid=%0b a=%h b=%h dest=%0d rw=%0b mr=%0b cnt=%0d",
                 tag, EXValid_OUT, EXOperandA_OUT, EXOperandB_OUT, EXDest_OUT,
                 EXRegWrite_OUT, EXMemRead_OUT, StallCount_OUT);
        chk({tag, ".valid"}, {31'b0, EXValid_OUT}, {31'b0, e.valid});
        chk({tag, ".rw"},    {31'b0, EXRegWrite_OUT}, {31'b0, e.rw});
        chk({tag, ".mr"},    {31'b0, EXMemRead_OUT}, {31'b0, e.mr});
        chk({tag, ".cnt"},   {30'b0, StallCount_OUT}, {30'b0, e.cnt});
        if (e.full) begin
            chk({tag, ".a"},    EXOperandA_OUT, e.a);
            chk({tag, ".b"},    EXOperandB_OUT, e.b);
            chk({tag, ".dest"}, {27'b0, EXDest_OUT}, {27'b0, e.dest});
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".valid"}, {31'b0, EXValid_OUT}, 32'h0);
        chk({tag, ".a"},     EXOperandA_OUT, 32'h0);
        chk({tag, ".b"},     EXOperandB_OUT, 32'h0);
        chk({tag, ".dest"},  {27'b0, EXDest_OUT}, 32'h0);
        chk({tag, ".rw"},    {31'b0, EXRegWrite_OUT}, 32'h0);
        chk({tag, ".mr"},    {31'b0, EXMemRead_OUT}, 32'h0);
        chk({tag, ".cnt"},   {30'b0, StallCount_OUT}, 32'h0);
        chk({tag, ".stall"}, {31'b0, Stall_OUT}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held with a would-be load-use hazard present: nothing may move.
        RESET = 0;
        idle();
        id(5'd5, 5'd0, 5'd1, 1, 0, 1, 0, 32'h0, 32'h0);
        mem(1, 1, 5'd5, 32'hDEAD);
        #3;
        check_all_zero("reset");
        @(negedge CLOCK);
        RESET = 1;
        idle();

        // WB bypass of r5.
        id(5'd5, 5'd0, 5'd1, 1, 0, 1, 0, 32'h0, 32'h0);
        wb(1, 5'd5, 32'h0000_1234);
        check_stall("wb_bypass.stall", 0);
        step("wb_bypass", 1, 1, 32'h0000_1234, 32'h0, 5'd1, 1, 0, 2'd0);

        // MEM beats WB on r7.
        idle();
        id(5'd0, 5'd7, 5'd2, 0, 1, 1, 0, 32'h11, 32'h55);
        mem(1, 0, 5'd7, 32'hAAAA_0000);
        wb(1, 5'd7, 32'hBBBB_0000);
        check_stall("prio.stall", 0);
        step("prio", 1, 1, 32'h0, 32'hAAAA_0000, 5'd2, 1, 0, 2'd0);

        // ALU -> use: add r3, then a reader of r3.
        idle();
        id(5'd0, 5'd0, 5'd3, 0, 0, 1, 0, 32'h0, 32'h0);
        step("add_r3", 1, 1, 32'h0, 32'h0, 5'd3, 1, 0, 2'd0);
        idle();
        id(5'd3, 5'd0, 5'd6, 1, 0, 1, 0, 32'h111, 32'h0);
        check_stall("alu_use.stall1", 1);
        step("alu_use.bubble", 0, 0, 32'h0, 32'h0, 5'd0, 0, 0, 2'd1);
        mem(1, 0, 5'd3, 32'h0000_3333);
        check_stall("alu_use.stall2", 0);
        step("alu_use", 1, 1, 32'h0000_3333, 32'h0, 5'd6, 1, 0, 2'd1);

        // Load -> use: lw r4, then a reader of r4 stalls twice.
        idle();
        id(5'd0, 5'd0, 5'd4, 0, 0, 1, 1, 32'h0, 32'h0);
        mem(1, 0, 5'd6, 32'h0000_6666);
        step("lw_r4", 1, 1, 32'h0, 32'h0, 5'd4, 1, 1, 2'd1);
        idle();
        id(5'd0, 5'd4, 5'd8, 0, 1, 1, 0, 32'h0, 32'h0);
        check_stall("ld_use.stall1", 1);
        step("ld_use.bubble1", 0, 0, 32'h0, 32'h0, 5'd0, 0, 0, 2'd2);
        mem(1, 1, 5'd4, 32'hDEAD_BEEF);
        check_stall("ld_use.stall2", 1);
        step("ld_use.bubble2", 0, 0, 32'h0, 32'h0, 5'd0, 0, 0, 2'd3);
        mem(0, 0, 5'd0, 32'h0);
        wb(1, 5'd4, 32'h0000_4444);
        check_stall("ld_use.stall3", 0);
        step("ld_use", 1, 1, 32'h0, 32'h0000_4444, 5'd8, 1, 0, 2'd3);

        // r0 is never forwarded.
        idle();
        id(5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 32'h99, 32'h98);
        mem(1, 0, 5'd0, 32'hFFFF_FFFF);
        wb(1, 5'd0, 32'h77);
        check_stall("r0.stall", 0);
        step("r0", 1, 1, 32'h0, 32'h0, 5'd0, 0, 0, 2'd3);

        // Unused Rt matching an EX load does not stall.
        idle();
        id(5'd0, 5'd0, 5'd9, 0, 0, 1, 1, 32'h0, 32'h0);
        step("lw_r9", 1, 1, 32'h0, 32'h0, 5'd9, 1, 1, 2'd3);
        idle();
        id(5'd0, 5'd9, 5'd10, 0, 0, 1, 0, 32'h0, 32'h5);
        check_stall("unused_rt.stall", 0);
        step("unused_rt", 1, 1, 32'h0, 32'h5, 5'd10, 1, 0, 2'd3);

        // Flush overrides a pending stall on r10.
        idle();
        id(5'd10, 5'd0, 5'd13, 1, 0, 1, 0, 32'h0, 32'h0);
        Flush_IN = 1;
        check_stall("flush.stall", 0);
        step("flush", 1, 0, 32'h0, 32'h0, 5'd0, 0, 0, 2'd3);

        // Saturation, then async reset in the middle of a load-use stall.
        idle();
        id(5'd0, 5'd0, 5'd11, 0, 0, 1, 1, 32'h0, 32'h0);
        step("lw_r11", 1, 1, 32'h0, 32'h0, 5'd11, 1, 1, 2'd3);
        idle();
        id(5'd11, 5'd0, 5'd12, 1, 0, 1, 0, 32'h0, 32'h0);
        check_stall("sat.stall", 1);
        step("sat.bubble", 0, 0, 32'h0, 32'h0, 5'd0, 0, 0, 2'd3);
        mem(1, 1, 5'd11, 32'h0000_0BAD);
        check_stall("midrst.stall", 1);
        #1;
        RESET = 0;
        #1;
        check_all_zero("midrst");
        @(negedge CLOCK);
        RESET = 1;
        idle();
        check_stall("post_rst.stall", 0);
        step("post_rst", 1, 0, 32'h0, 32'h0, 5'd0, 0, 0, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- Decode-to-execute pipeline stage that sits directly downstream of the register file.
- Takes the two raw read ports plus the ID instruction's control fields and resolves RAW hazards. Operands are bypassed from the MEM and WB stages. Interlock stalls are raised when a value is not yet available.
- Result is latched into the ID/EX pipeline register that feeds the ALU.
- A saturating stall counter exposes interlock cost for performance runs.

Parameters:
- DATA_W, 32, operand and result width
- REG_AW, 5, register address width
- CNT_W, 32, stall-counter width

Ports:
- CLOCK  in  1  system clock; all state updates on rising edge
- RESET  in  1  asynchronous active-low reset; one clock; polarity and synchronicity fixed
- InstrValid_IN  in  1  ID holds a real instruction
- Rs_IN  in  REG_AW  source register 1 address (also drives ReadRegister1)
- Rt_IN  in  REG_AW  source register 2 address
- Dest_IN  in  REG_AW  destination register of ID instruction
- UsesRs_IN / UsesRt_IN  in  1 each  instruction actually reads Rs / Rt
- RegWrite_IN  in  1  ID instruction writes Dest
- MemRead_IN  in  1  ID instruction is a load
- RegData1_IN / RegData2_IN  in  DATA_W  register-file read data for Rs / Rt
- MEMRegWrite_IN  in  1  EX/MEM instruction writes a register
- MEMMemRead_IN  in  1  EX/MEM instruction is a load (result not yet available)
- MEMDest_IN  in  REG_AW  EX/MEM destination
- MEMResult_IN  in  DATA_W  EX/MEM ALU result
- WBWriteEnable_IN  in  1  same signal driving the register-file write enable
- WBWriteRegister_IN  in  REG_AW  WB destination
- WBWriteData_IN  in  DATA_W  WB data
- Flush_IN  in  1  squash the ID instruction (branch redirect)
- Stall_OUT  out  1  combinational; hold PC and IF/ID
- EXValid_OUT  out  1  ID/EX holds a real instruction
- EXOperandA_OUT / EXOperandB_OUT  out  DATA_W  resolved operands
- EXDest_OUT  out  REG_AW  latched destination
- EXRegWrite_OUT / EXMemRead_OUT  out  1 each  latched control
- StallCount_OUT  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (RESET low, async):
  - All EX*_OUT outputs clear to 0, including EXValid_OUT.
  - StallCount_OUT clears to 0.
  - Stall_OUT is 0 while reset is asserted.
  - Reset mid-stall discards the pending ID instruction state.
- Operand resolution (combinational, per operand, source address S):
  - S == 0 gives 0; register 0 is never forwarded, even if a producer targets it.
  - Otherwise, if MEMRegWrite_IN and !MEMMemRead_IN and MEMDest_IN == S, use MEMResult_IN.
  - Otherwise, if WBWriteEnable_IN and WBWriteRegister_IN == S, use WBWriteData_IN. This covers a register-file write landing on the same edge the stage captures.
  - Otherwise use RegData*_IN.
- Hazard (source S is used and S != 0):
  - Case 1: EXValid_OUT and EXRegWrite_OUT and EXDest_OUT == S. The producer is in EX and its result does not exist yet.
  - Case 2: MEMRegWrite_IN and MEMMemRead_IN and MEMDest_IN == S. Load data is not ready.
- Stall_OUT = InstrValid_IN & !Flush_IN & (hazard on Rs | hazard on Rt).
- Penalty: ALU->use costs 1 stall cycle; load->use costs 2 stall cycles. Consumers count on exactly these penalties.
- Each rising edge, in priority order:
  - Flush_IN: EXValid_OUT <= 0, other EX fields <= 0. Flush overrides stall.
  - Else Stall_OUT: insert a bubble (EXValid_OUT <= 0, EXRegWrite_OUT <= 0, EXMemRead_OUT <= 0).
  - Else: capture resolved operands and Dest/control; EXValid_OUT <= InstrValid_IN.
  - Bubbles and invalid instructions always carry EXRegWrite_OUT = EXMemRead_OUT = 0.
- Latency: one cycle from ID inputs to EX outputs when not stalled.
- StallCount_OUT increments on each edge where Stall_OUT = 1. It saturates at all-ones and never wraps.
- Simultaneous MEM and WB match on the same register: MEM wins (younger value).

Decomposition:
- Shared package `pipe_pkg` holds:
  - DATA_W, REG_AW and the REG_ZERO constant
  - the ID/EX control-field bundle typedef (valid, regwrite, memread, dest)
- Natural sub-module: `operand_bypass_mux`. It is combinational, handles one operand, and outputs resolved data plus a hazard flag. It is instantiated twice (Rs, Rt).

Test Plan:
- WB bypass: WB writes r5 = 0x00001234 while ID reads r5 (RegData1_IN = 0) -> next cycle EXOperandA_OUT = 0x00001234, Stall_OUT = 0.
- Priority: MEM r7 = 0xAAAA0000 and WB r7 = 0xBBBB0000 while ID uses Rt = r7 -> EXOperandB_OUT = 0xAAAA0000.
- ALU->use:
  - `add r3` in EX, next instruction uses Rs = r3 -> Stall_OUT high for 1 cycle, one bubble (EXValid_OUT = 0), StallCount_OUT = 1.
  - Then EXOperandA_OUT = MEMResult_IN.
- Load->use: `lw r4` followed by a user of r4 -> exactly 2 stall cycles and 2 bubbles; operand later taken from WBWriteData_IN; StallCount_OUT = 2.
- r0 and unused sources:
  - MEM writes r0 = 0xFFFFFFFF, ID reads r0 -> operand 0, no stall.
  - EX load to r9 with UsesRt_IN = 0 and Rt = r9 -> no stall.
- Flush/reset:
  - Flush_IN during a pending stall -> Stall_OUT = 0, EXValid_OUT = 0 next edge.
  - RESET low mid-stream -> all outputs 0 immediately, without waiting for a clock edge.
